// File: rtl/spart_fifo_bus_intf.sv
// Registered bus front-end for the SPART: a TX FIFO and an RX FIFO decouple
// CPU bus transfers from SPART byte timing, with status/control registers and
// a level interrupt. Contains a small synchronous FIFO and the top module.

// Synchronous FIFO with occupancy count. DEPTH must be a power of two so the
// pointers wrap naturally at their bit width.
module spart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array: written on push only.
  // NOTE: the data array is deliberately not reset; only pointers and count
  // define validity, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and count; a simultaneous push and pop leaves count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module spart_fifo_bus_intf #(
  parameter logic [5:0] BASE_WORD = 6'h07,
  parameter int         TX_DEPTH  = 8,
  parameter int         RX_DEPTH  = 8,
  localparam int        TX_CW     = $clog2(TX_DEPTH) + 1,
  localparam int        RX_CW     = $clog2(RX_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_i,
  input  logic        read_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_read_o,
  output logic        irq_o
);

  localparam logic [1:0] REG_TXDATA = 2'b00;
  localparam logic [1:0] REG_RXDATA = 2'b01;
  localparam logic [1:0] REG_STATUS = 2'b10;
  localparam logic [1:0] REG_CTRL   = 2'b11;

  // FIFO state
  logic [TX_CW-1:0] tx_count;
  logic [RX_CW-1:0] rx_count;
  logic             tx_empty, tx_full, rx_empty, rx_full;
  logic [7:0]       rx_head;
  logic             tx_push, tx_pop, rx_push, rx_pop;

  // Bus handshake state
  logic        busy;
  logic        ack_q;
  logic [31:0] data_q;
  logic        rx_read_q;

  // Control / status state
  logic rx_ie, tx_empty_ie, rx_ovf;

  // Decode
  logic        cs, req, target_ready, accept, ctrl_wr, rx_ovf_set;
  logic [1:0]  sel;
  logic [31:0] status_word;
  logic [31:0] rd_data;

  // Address and data bits outside the register window have no function.
  logic unused_bits;
  assign unused_bits = ^{addr_i[31:8], data_i[31:8]};

  assign cs  = (addr_i[7:2] == BASE_WORD);
  assign sel = addr_i[1:0];
  assign req = write_i || read_i;

  // Readiness uses registered FIFO state only; write has priority over read.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    target_ready = 1'b1;
    if (write_i)     target_ready = (sel != REG_TXDATA) || !tx_full;
    else if (read_i) target_ready = (sel != REG_RXDATA) || !rx_empty;
  end

  assign accept  = cs && req && !busy && target_ready;
  assign tx_push = accept && write_i && (sel == REG_TXDATA);
  assign rx_pop  = accept && !write_i && (sel == REG_RXDATA);
  assign ctrl_wr = accept && write_i && (sel == REG_CTRL);

  // TX drain to the SPART transmitter.
  assign tx_valid_o = !tx_empty;
  assign tx_pop     = tx_valid_o && tx_ready_i;

  // RX fill: consume a byte only if the previous cycle did not, giving the
  // SPART one cycle to drop RDA. Gated by rst_n so no pulse leaks in reset.
  assign rx_push    = rst_n && rx_valid_i && !rx_read_q && !rx_full;
  assign rx_read_o  = rx_push;
  assign rx_ovf_set = rx_valid_i && !rx_read_q && rx_full;

  spart_sync_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .wdata (data_i[7:0]),
    .pop   (tx_pop),
    .rdata (tx_data_o),
    .count (tx_count),
    .empty (tx_empty),
    .full  (tx_full)
  );

  spart_sync_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .wdata (rx_data_i),
    .pop   (rx_pop),
    .rdata (rx_head),
    .count (rx_count),
    .empty (rx_empty),
    .full  (rx_full)
  );

  // Assemble the STATUS word from registered state.
  always_comb begin
    status_word                = '0;
    status_word[0]             = !rx_empty;
    status_word[1]             = !tx_full;
    status_word[2]             = tx_empty;
    status_word[3]             = rx_full;
    status_word[4]             = rx_ovf;
    status_word[8 +: RX_CW]    = rx_count;
    status_word[16 +: TX_CW]   = tx_count;
  end

  // Read-data mux; writes and write-only/unmapped reads return zero.
  always_comb begin
    rd_data = '0;
    if (!write_i) begin
      case (sel)
        REG_RXDATA: rd_data = {24'h0, rx_head};
        REG_STATUS: rd_data = status_word;
        REG_CTRL:   rd_data = {30'h0, tx_empty_ie, rx_ie};
        default:    rd_data = '0;
      endcase
    end
  end

  // Ack/data registers and the busy flag that blocks re-acceptance until
  // the master drops its request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      data_q    <= '0;
      busy      <= 1'b0;
      rx_read_q <= 1'b0;
    end else begin
      ack_q     <= accept;
      data_q    <= accept ? rd_data : '0;
      rx_read_q <= rx_push;
      if (accept)   busy <= 1'b1;
      else if (!req) busy <= 1'b0;
    end
  end

  assign ack_o  = ack_q;
  assign data_o = data_q;

  // Control register, sticky overflow flag (set wins over clear) and irq.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_ie       <= 1'b0;
      tx_empty_ie <= 1'b0;
      rx_ovf      <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      if (ctrl_wr) {tx_empty_ie, rx_ie} <= data_i[1:0];
      if (rx_ovf_set)                rx_ovf <= 1'b1;
      else if (ctrl_wr && data_i[2]) rx_ovf <= 1'b0;
      irq_o <= (rx_ie && !rx_empty) || (tx_empty_ie && tx_empty) || rx_ovf;
    end
  end

endmodule

// File: tb/tb_spart_fifo_bus_intf.sv
// Directed self-checking bench for spart_fifo_bus_intf. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_spart_fifo_bus_intf;

  localparam logic [7:0] A_TX   = 8'h1C;
  localparam logic [7:0] A_RX   = 8'h1D;
  localparam logic [7:0] A_STAT = 8'h1E;
  localparam logic [7:0] A_CTRL = 8'h1F;
  localparam logic [7:0] A_NOCS = 8'h20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_i, read_i;
  logic [31:0] addr_i, data_i, data_o;
  logic        ack_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o, tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i, rx_read_o, irq_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spart_fifo_bus_intf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_i    (write_i),
    .read_i     (read_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .ack_o      (ack_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_read_o  (rx_read_o),
    .irq_o      (irq_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_start(input logic wr, input logic [7:0] a, input logic [31:0] d);
    write_i = wr;
    read_i  = !wr;
    addr_i  = {24'h0, a};
    data_i  = d;
  endtask

  // Wait (bounded) for ack, drop the request, then idle one cycle so busy clears.
  task automatic bus_finish(input string tag, input int budget, output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd  = '0;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge clk);
      if (ack_o) begin
        got = 1'b1;
        rd  = data_o;
      end
    end
    write_i = 1'b0;
    read_i  = 1'b0;
    check({tag, " ack"}, {31'h0, got}, 32'd1);
    @(negedge clk);
  endtask

  task automatic bus_write(input string tag, input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd;
    bus_start(1'b1, a, d);
    bus_finish(tag, 8, rd);
    check({tag, " wdata0"}, rd, 32'h0);
  endtask

  task automatic bus_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    bus_start(1'b0, a, 32'h0);
    bus_finish(tag, 8, rd);
    check(tag, rd, exp);
  endtask

  // SPART RX model: raise RDA, expect the consume pulse, drop RDA.
  task automatic rx_send(input string tag, input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    #1;
    check(tag, {31'h0, rx_read_o}, 32'd1);
    @(negedge clk);
    rx_valid_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int acks;
    logic [31:0] rd;
    rst_n = 1'b0; write_i = 1'b0; read_i = 1'b0; addr_i = '0; data_i = '0;
    tx_ready_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst ack", {31'h0, ack_o}, 32'd0);
    check("rst data", data_o, 32'h0);
    check("rst irq", {31'h0, irq_o}, 32'd0);
    check("rst tx_valid", {31'h0, tx_valid_o}, 32'd0);
    check("rst rx_read", {31'h0, rx_read_o}, 32'd0);
    bus_read("status after rst", A_STAT, 32'h0000_0006);
    check("irq idle", {31'h0, irq_o}, 32'd0);

    // Register map corner cases
    bus_write("write status", A_STAT, 32'hFFFF_FFFF);
    bus_read("read txdata", A_TX, 32'h0);
    bus_read("status unchanged", A_STAT, 32'h0000_0006);
    bus_start(1'b0, A_NOCS, 32'h0);
    acks = 0;
    repeat (4) begin @(negedge clk); if (ack_o) acks++; end
    read_i = 1'b0;
    @(negedge clk);
    check("no-cs acks", acks, 0);

    // TX fill to full with the transmitter stalled
    for (int i = 0; i < 8; i++) bus_write("tx fill", A_TX, 32'h41 + i);
    bus_start(1'b1, A_TX, 32'h49);
    repeat (3) begin @(negedge clk); check("tx full stall", {31'h0, ack_o}, 32'd0); end
    check("tx head 41", {24'h0, tx_data_o}, 32'h41);
    tx_ready_i = 1'b1;
    @(negedge clk);
    tx_ready_i = 1'b0;
    bus_finish("tx 9th", 8, rd);
    check("tx head 42", {24'h0, tx_data_o}, 32'h42);
    bus_read("status tx full", A_STAT, 32'h0008_0000);

    // TX drain order
    tx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("tx drain", {24'h0, tx_data_o}, 32'h42 + i);
      @(negedge clk);
    end
    tx_ready_i = 1'b0;
    check("tx drained", {31'h0, tx_valid_o}, 32'd0);

    // RX fill and reads, third read stalls until a byte arrives
    rx_send("rx pulse 10", 8'h10);
    rx_send("rx pulse 20", 8'h20);
    bus_read("status rx2", A_STAT, 32'h0000_0207);
    bus_read("rx 10", A_RX, 32'h10);
    bus_read("rx 20", A_RX, 32'h20);
    bus_start(1'b0, A_RX, 32'h0);
    repeat (3) begin @(negedge clk); check("rx empty stall", {31'h0, ack_o}, 32'd0); end
    rx_data_i  = 8'h30;
    rx_valid_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0;
    bus_finish("rx 30", 8, rd);
    check("rx 30 data", rd, 32'h30);

    // Held request yields exactly one ack
    bus_start(1'b0, A_STAT, 32'h0);
    acks = 0;
    repeat (5) begin @(negedge clk); if (ack_o) acks++; end
    check("hold single ack", acks, 1);
    read_i = 1'b0;
    @(negedge clk);
    bus_read("reassert ack", A_STAT, 32'h0000_0006);

    // RX overflow
    for (int i = 0; i < 8; i++) rx_send("rx fill", 8'h60 + 8'(i));
    bus_read("status rx full", A_STAT, 32'h0000_080F);
    rx_valid_i = 1'b1;
    rx_data_i  = 8'hEE;
    #1;
    check("no read when full", {31'h0, rx_read_o}, 32'd0);
    repeat (2) @(negedge clk);
    rx_valid_i = 1'b0;
    @(negedge clk);
    bus_read("status ovf", A_STAT, 32'h0000_081F);
    check("irq on ovf", {31'h0, irq_o}, 32'd1);
    bus_write("ctrl clr ovf", A_CTRL, 32'h4);
    check("irq after clr", {31'h0, irq_o}, 32'd0);
    bus_read("status ovf clr", A_STAT, 32'h0000_080F);
    bus_read("ctrl reads 0", A_CTRL, 32'h0);
    for (int i = 0; i < 8; i++) bus_read("rx drain", A_RX, 32'h60 + i);
    bus_read("status rx empty", A_STAT, 32'h0000_0006);

    // RX interrupt
    bus_write("ctrl rx_ie", A_CTRL, 32'h1);
    bus_read("ctrl readback", A_CTRL, 32'h1);
    check("irq rx empty", {31'h0, irq_o}, 32'd0);
    rx_send("rx pulse 55", 8'h55);
    check("irq rx avail", {31'h0, irq_o}, 32'd1);
    bus_start(1'b0, A_RX, 32'h0);
    bus_finish("rx 55", 8, rd);
    check("rx 55 data", rd, 32'h55);
    check("irq after pop", {31'h0, irq_o}, 32'd0);

    // TX-empty interrupt
    bus_write("ctrl tx_empty_ie", A_CTRL, 32'h2);
    check("irq tx empty", {31'h0, irq_o}, 32'd1);
    bus_write("ctrl off", A_CTRL, 32'h0);
    check("irq off", {31'h0, irq_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
